// File: rtl/hh_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// hh_neuron_scheduler
//
// Shares one Hodgkin-Huxley integration datapath across NUM_NEURONS neuron
// slots. A free-running timestep counter (TICK_DIV clk cycles per step) raises
// a pending flag. Each pending step starts one sweep. A sweep issues one
// datapath update per slot in index order and collects the returned spike
// flags. If any slot spiked, the sweep ends by handing the spike vector to the
// STDP engine.
//
// Handshakes:
//   dp_start / dp_done : dp_start is a one-cycle pulse that launches the update
//                        of slot dp_idx. The datapath answers with a one-cycle
//                        dp_done carrying dp_spike. dp_done is sampled only
//                        while the scheduler waits for it.
//   stdp_req / stdp_ack: stdp_req is a level. stdp_spikes stays stable while
//                        stdp_req is high. The transfer completes on the first
//                        cycle in which stdp_ack is sampled high. stdp_ack is
//                        ignored while stdp_req is low.
//
// Optional feature, enabled by defining the macro SCHED_WATCHDOG_EN:
//   a watchdog bounds the WAIT and STDP states to WD_CYCLES cycles. On timeout
//   it sets the sticky wd_err and abandons the sweep. Without the macro,
//   wd_err is tied low and both states wait indefinitely.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous reset, active HIGH (legacy name)
//   en           in   tick counter enable; a sweep in flight always completes
//   dp_start     out  one-cycle pulse: update slot dp_idx
//   dp_idx       out  slot being updated (holds its value between pulses)
//   dp_done      in   one-cycle pulse: update finished
//   dp_spike     in   spike flag, valid with dp_done
//   stdp_req     out  STDP request level
//   stdp_spikes  out  per-slot spike vector (holds after the request ends)
//   stdp_ack     in   STDP engine accepted the request
//   busy         out  high whenever the FSM is not in IDLE
//   overrun      out  sticky: a timestep tick was lost
//   step_count   out  completed sweeps, wraps from 0xFFFF to 0
//   wd_err       out  sticky watchdog timeout
//   dbg_state    out  current FSM state encoding (0 IDLE, 1 ISSUE, 2 WAIT, 3 STDP)
// -----------------------------------------------------------------------------
module hh_neuron_scheduler #(
    parameter int NUM_NEURONS = 2,
    parameter int IDX_W       = 1,
    parameter int TICK_DIV    = 500,
    parameter int WD_CYCLES   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   dp_start,
    output logic [IDX_W-1:0]       dp_idx,
    input  logic                   dp_done,
    input  logic                   dp_spike,
    output logic                   stdp_req,
    output logic [NUM_NEURONS-1:0] stdp_spikes,
    input  logic                   stdp_ack,
    output logic                   busy,
    output logic                   overrun,
    output logic [15:0]            step_count,
    output logic                   wd_err,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_STDP  = 2'd3
    } state_t;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_NEURONS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       tick_cnt;
    logic                   pending;
    logic [IDX_W-1:0]       idx;
    logic [NUM_NEURONS-1:0] spike_vec;
    logic [NUM_NEURONS-1:0] vec_upd;
    logic                   tick_wrap;
    logic                   consume;

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign wd_err = 1'b0;
`endif

    assign dbg_state = state;

    // The wrap cycle is the cycle in which the count sits at TICK_DIV-1.
    assign tick_wrap = en && (tick_cnt == TICK_LAST);
    // IDLE takes the pending step on the same edge it leaves for ISSUE.
    assign consume   = (state == S_IDLE) && pending;

    // Spike vector including the result arriving this cycle, so the decision
    // to enter STDP sees the final slot's spike.
    always_comb begin
        vec_upd      = spike_vec;
        vec_upd[idx] = dp_spike;
    end

    // -------------------------------------------------------------------------
    // Timestep counter and pending / overrun bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tick_cnt <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (en) begin
                tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            end
            if (tick_wrap) begin
                // A new step always wins over consumption in the same cycle.
                // The step is only lost if the previous one is still waiting.
                pending <= 1'b1;
                if (pending && !consume) begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sweep FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            spike_vec   <= '0;
            dp_start    <= 1'b0;
            dp_idx      <= '0;
            stdp_req    <= 1'b0;
            stdp_spikes <= '0;
            busy        <= 1'b0;
            step_count  <= '0;
`ifdef SCHED_WATCHDOG_EN
            wd_cnt      <= '0;
            wd_err      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        idx       <= '0;
                        spike_vec <= '0;
                        dp_idx    <= '0;
                        dp_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    dp_start <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
                    wd_cnt   <= '0;
`endif
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (dp_done) begin
                        spike_vec <= vec_upd;
`ifdef SCHED_WATCHDOG_EN
                        wd_cnt    <= '0;
`endif
                        if (idx != IDX_LAST) begin
                            idx      <= idx + 1'b1;
                            dp_idx   <= idx + 1'b1;
                            dp_start <= 1'b1;
                            state    <= S_ISSUE;
                        end else if (|vec_upd) begin
                            stdp_req    <= 1'b1;
                            stdp_spikes <= vec_upd;
                            state       <= S_STDP;
                        end else begin
                            step_count <= step_count + 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
`ifdef SCHED_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        // Datapath never answered: abandon the sweep uncounted.
                        wd_err <= 1'b1;
                        wd_cnt <= '0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                S_STDP: begin
                    if (stdp_ack) begin
                        stdp_req   <= 1'b0;
                        step_count <= step_count + 1'b1;
                        busy       <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
                        wd_cnt     <= '0;
`endif
                        state      <= S_IDLE;
                    end
`ifdef SCHED_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        // STDP engine never accepted: drop the request uncounted.
                        wd_err   <= 1'b1;
                        stdp_req <= 1'b0;
                        wd_cnt   <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hh_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for hh_neuron_scheduler with NUM_NEURONS=2, TICK_DIV=8,
// WD_CYCLES=16. Inputs are driven and outputs sampled on the falling edge.
//
// Timing reference used for the expected values: reset is released on a
// falling edge, and rising edges after release are numbered 1, 2, ...
// The counter wraps during the cycle after edge 7. Edge 8 sets pending, and
// edge 9 enters ISSUE, so the first dp_start is seen after edge 9. Later
// wraps set pending at edges 16, 24, 32, ...
// If slot N's dp_done is driven L falling edges after its dp_start is seen,
// the next ISSUE (or the exit from WAIT) occurs L+1 edges later.
// -----------------------------------------------------------------------------
module tb_hh_neuron_scheduler;

  localparam int NN = 2;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          dp_start;
  logic [0:0]    dp_idx;
  logic          dp_done;
  logic          dp_spike;
  logic          stdp_req;
  logic [NN-1:0] stdp_spikes;
  logic          stdp_ack;
  logic          busy;
  logic          overrun;
  logic [15:0]   step_count;
  logic          wd_err;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          l0;
    int          l1;
    logic        sp0;
    logic        sp1;
    int          ack_dly;
    logic        exp_req;
    logic [1:0]  exp_spikes;
    logic        exp_ovr;
    int          exp_gap;
    logic        noise;
    logic [15:0] exp_step;
  } vec_t;

  vec_t vecs[6];

  hh_neuron_scheduler #(
    .NUM_NEURONS(NN),
    .IDX_W(1),
    .TICK_DIV(8),
    .WD_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .dp_start(dp_start),
    .dp_idx(dp_idx),
    .dp_done(dp_done),
    .dp_spike(dp_spike),
    .stdp_req(stdp_req),
    .stdp_spikes(stdp_spikes),
    .stdp_ack(stdp_ack),
    .busy(busy),
    .overrun(overrun),
    .step_count(step_count),
    .wd_err(wd_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, required end before 500000");
    $fatal(1, "time limit");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    dp_done  = 1'b0;
    dp_spike = 1'b0;
    stdp_ack = 1'b0;
    en       = 1'b1;
    rst_n    = 1'b1;
    #1;
    check("reset_outputs",
          {dp_start, dp_idx, stdp_req, stdp_spikes, busy, overrun, step_count, wd_err, dbg_state},
          32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Count falling edges until dp_start is seen (bounded).
  task automatic wait_start(output int n);
    n = 0;
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (dp_start) break;
    end
  endtask

  // Runs one sweep starting at the falling edge where dp_start for slot 0 is
  // visible. It ends at the falling edge where the next sweep's dp_start shows.
  task automatic sweep(input vec_t v);
    int bad;
    int n;
    check("idx0", dp_idx, 0);
    check("busy_in_sweep", busy, 1);
    bad = 0;
    repeat (v.l0) begin
      @(negedge clk);
      if (dp_start) bad++;
    end
    dp_done = 1'b1; dp_spike = v.sp0;
    @(negedge clk);
    dp_done = 1'b0; dp_spike = 1'b0;
    check("start_slot1", dp_start, 1);
    check("idx1", dp_idx, 1);
    repeat (v.l1) begin
      @(negedge clk);
      if (dp_start) bad++;
    end
    dp_done = 1'b1; dp_spike = v.sp1;
    @(negedge clk);
    dp_done = 1'b0; dp_spike = 1'b0;
    check("no_start_in_wait", bad, 0);
    if (v.exp_req) begin
      check("stdp_req_rise", stdp_req, 1);
      check("stdp_spikes", stdp_spikes, v.exp_spikes);
      check("step_before_ack", step_count, v.exp_step - 16'd1);
      bad = 0;
      repeat (v.ack_dly - 1) begin
        @(negedge clk);
        if (!stdp_req || stdp_spikes !== v.exp_spikes || step_count !== v.exp_step - 16'd1) bad++;
      end
      check("stdp_req_hold", bad, 0);
      stdp_ack = 1'b1;
      @(negedge clk);
      stdp_ack = 1'b0;
      check("stdp_req_fall", stdp_req, 0);
      check("stdp_spikes_held", stdp_spikes, v.exp_spikes);
    end else begin
      check("no_stdp_req", stdp_req, 0);
    end
    check("step_count", step_count, v.exp_step);
    check("busy_idle", busy, 0);
    check("state_idle", dbg_state, 0);
    check("overrun", overrun, v.exp_ovr);
    if (v.noise) begin
      // Stray handshakes while idle must be ignored.
      dp_done = 1'b1; dp_spike = 1'b1; stdp_ack = 1'b1;
    end
    wait_start(n);
    dp_done = 1'b0; dp_spike = 1'b0; stdp_ack = 1'b0;
    check("gap_to_next_start", n, v.exp_gap);
    check("step_after_gap", step_count, v.exp_step);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int bad;
    vec_t va;
    vec_t vb;

    rst_n = 1'b1; en = 1'b1;
    dp_done = 1'b0; dp_spike = 1'b0; stdp_ack = 1'b0;

    vecs[0] = '{l0:3,  l1:3,  sp0:0, sp1:0, ack_dly:0, exp_req:0, exp_spikes:2'b00, exp_ovr:0, exp_gap:1, noise:0, exp_step:16'd1};
    vecs[1] = '{l0:3,  l1:3,  sp0:0, sp1:1, ack_dly:5, exp_req:1, exp_spikes:2'b10, exp_ovr:0, exp_gap:1, noise:0, exp_step:16'd1};
    vecs[2] = '{l0:20, l1:20, sp0:0, sp1:0, ack_dly:0, exp_req:0, exp_spikes:2'b00, exp_ovr:1, exp_gap:1, noise:0, exp_step:16'd1};
    vecs[3] = '{l0:1,  l1:1,  sp0:0, sp1:0, ack_dly:0, exp_req:0, exp_spikes:2'b00, exp_ovr:0, exp_gap:4, noise:1, exp_step:16'd1};
    vecs[4] = '{l0:2,  l1:1,  sp0:1, sp1:1, ack_dly:1, exp_req:1, exp_spikes:2'b11, exp_ovr:0, exp_gap:2, noise:0, exp_step:16'd1};
    vecs[5] = '{l0:1,  l1:2,  sp0:1, sp1:0, ack_dly:2, exp_req:1, exp_spikes:2'b01, exp_ovr:0, exp_gap:1, noise:0, exp_step:16'd1};

    // Table-driven sweeps, each from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      wait_start(n);
      check("first_start_edges", n, 9);
      sweep(vecs[i]);
    end

    // Two sweeps in a row: the spike vector is cleared between sweeps.
    do_reset();
    wait_start(n);
    va = '{l0:1, l1:1, sp0:1, sp1:0, ack_dly:1, exp_req:1, exp_spikes:2'b01, exp_ovr:0, exp_gap:3, noise:0, exp_step:16'd1};
    vb = '{l0:1, l1:1, sp0:0, sp1:1, ack_dly:1, exp_req:1, exp_spikes:2'b10, exp_ovr:0, exp_gap:3, noise:0, exp_step:16'd2};
    sweep(va);
    sweep(vb);

    // A wrap at edge 24 coincides with IDLE consuming the step set at edge 16.
    // Pending must stay set with no overrun. The wrap at edge 32 then finds
    // pending still set and records an overrun.
    do_reset();
    wait_start(n);
    va = '{l0:6, l1:6, sp0:0, sp1:0, ack_dly:0, exp_req:0, exp_spikes:2'b00, exp_ovr:0, exp_gap:1, noise:0, exp_step:16'd1};
    vb = '{l0:6, l1:6, sp0:0, sp1:0, ack_dly:0, exp_req:0, exp_spikes:2'b00, exp_ovr:1, exp_gap:1, noise:0, exp_step:16'd2};
    sweep(va);
    check("overrun_collision", overrun, 0);
    sweep(vb);

    // en held low at count 5 for 50 cycles.
    do_reset();
    repeat (5) @(negedge clk);
    en = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (dp_start || busy) bad++;
    end
    check("frozen_no_start", bad, 0);
    en = 1'b1;
    wait_start(n);
    check("resume_start_edges", n, 4);
    check("resume_idx", dp_idx, 0);

    // Reset asserted while a STDP request is outstanding.
    do_reset();
    wait_start(n);
    @(negedge clk);
    dp_done = 1'b1; dp_spike = 1'b1;
    @(negedge clk);
    dp_done = 1'b0; dp_spike = 1'b0;
    @(negedge clk);
    dp_done = 1'b1; dp_spike = 1'b1;
    @(negedge clk);
    dp_done = 1'b0; dp_spike = 1'b0;
    check("req_before_reset", {stdp_req, stdp_spikes, dbg_state}, {1'b1, 2'b11, 2'd3});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_stdp",
          {dp_start, dp_idx, stdp_req, stdp_spikes, busy, overrun, step_count, wd_err, dbg_state},
          32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    // The first pulse lands on the 9th rising edge after release, i.e. in the
    // (TICK_DIV+2)-th cycle when the release cycle counts as the first.
    wait_start(n);
    check("restart_start_edges", n, 9);

    // Datapath never returns dp_done.
    do_reset();
    wait_start(n);
`ifdef SCHED_WATCHDOG_EN
    repeat (16) @(negedge clk);
    check("wd_not_yet", wd_err, 0);
    @(negedge clk);
    check("wd_err_set", wd_err, 1);
    check("wd_busy_low", busy, 0);
    check("wd_step_unchanged", step_count, 0);
    wait_start(n);
    check("wd_restart_gap", n, 1);
    check("wd_restart_idx", dp_idx, 0);
`else
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (!busy || wd_err || dp_start) bad++;
    end
    check("stuck_wait_busy", bad, 0);
    check("wd_err_tied", wd_err, 0);
    check("stuck_state_wait", dbg_state, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
